serial_add_arbiter: RTL
=======================

# serial_add_arbiter

Shares one `full_adder` cell between two requesters, using it bit-serially to add WIDTH-bit operands.
- Arbitrates between two request ports with round-robin priority.
- Latches the winner's operands and steps the single full adder once per cycle, LSB first, with a registered carry.
- Returns the sum, carry-out and requester ID with a one-cycle done pulse.
- Sits between client blocks and the shared adder, trading latency (WIDTH cycles) for area.

## Interface
- WIDTH, 8, operand/sum width in bits, ≥1
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, asynchronous, active-low
- req0  input  1  requester 0 wants an add; held high until gnt0
- a0, b0  input  WIDTH  requester 0 operands
- cin0  input  1  requester 0 carry-in
- req1, a1, b1, cin1  input  1/WIDTH/WIDTH/1  same as above, for requester 1
- gnt0, gnt1  output  1  one-cycle grant pulse; that requester's operands have been captured
- busy  output  1  high while the adder is stepping (RUN state)
- done  output  1  one-cycle pulse; sum/cout/done_id valid
- done_id  output  1  requester that owns the current result
- sum  output  WIDTH  result; held until the next done
- cout  output  1  final carry; held until the next done

## Operation
- States:
  - IDLE: nothing in flight.
  - RUN: WIDTH bit steps in progress.
  - DONE: one cycle, result presented.
- Reset (rst_n low, takes effect immediately, no clock needed):
  - State returns to IDLE.
  - All outputs go to 0: gnt0, gnt1, busy, done, done_id, sum, cout.
  - Bit counter, carry register and operand shift registers clear.
  - Round-robin pointer `last` = 1, so requester 0 wins the first tie.
- Arbitration is evaluated in IDLE and in DONE at each rising edge:
  - Only one req high: that requester wins.
  - Both high: the requester ≠ `last` wins; `last` is updated to the winner.
  - Neither high: IDLE stays IDLE; DONE goes to IDLE.
- On a win:
  - Capture the winner's a, b and cin into shift registers and the carry register.
  - Pulse the matching gnt for the next cycle.
  - Counter ← 0; state → RUN.
- RUN, each edge:
  - The full_adder takes a_sr[0], b_sr[0] and the carry register.
  - Its S output shifts into the MSB of the result register; the result is assembled LSB-first.
  - Its Cout output is stored in the carry register.
  - a_sr and b_sr shift right by one; the counter increments.
- RUN completion, on the edge where the counter reaches WIDTH−1:
  - sum ← the completed result; cout ← the final carry; done_id ← the owner; done ← 1.
  - State → DONE.
- Request handling:
  - Requests arriving during RUN are ignored, not queued.
  - A requester must keep req high until it sees its gnt; the block does not remember a dropped request.
  - Operands are sampled only on the grant edge, so they may change after gnt.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No other flags.

## Timing
- Edge E0 (IDLE or DONE, req seen):
  - gnt_x = 1 during cycle E0→E1.
  - busy = 1 from E0 up to, but not including, the cycle after EW.
- Edges E1..EW process bits 0..WIDTH−1.
  - After EW: done = 1 for exactly one cycle; sum, cout and done_id are updated at EW.
  - busy = 0 in the DONE cycle.
- Latency:
  - req-sampling edge to done asserted: WIDTH cycles after the grant cycle.
  - WIDTH+1 edges in total.
- Back-to-back throughput:
  - A request pending during DONE is granted at edge EW+1.
  - That new gnt coincides with the cycle after done.
  - Sustained rate: one add per WIDTH+1 cycles.
- gnt0 and gnt1 are never high in the same cycle; done and gnt are never high in the same cycle.
- Reset mid-RUN:
  - The operation is dropped and no done is issued.
  - After rst_n rises, arbitration restarts with `last` = 1.
- WIDTH = 1: RUN lasts exactly one edge; done follows the grant cycle directly.

## Test plan
- Single add, WIDTH=8:
  - Stimulus: req0, a0=0x5A, b0=0x3C, cin0=0.
  - Required: gnt0 one cycle after req0 is sampled; done 8 cycles later with sum=0x96, cout=0, done_id=0; busy high for exactly 8 cycles.
- Overflow with carry-in:
  - Stimulus: req1, a1=0xFF, b1=0x01, cin1=1.
  - Required: sum=0x01, cout=1, done_id=1.
  - After that, change a1 on the cycle after gnt1; the result must be unchanged.
- Tie after reset:
  - Stimulus: req0 and req1 rise together; req0: 0x10+0x20; req1: 0x80+0x80.
  - Required: gnt0 first, then done with 0x30/cout 0/id 0; gnt1 in the cycle right after done, then done with 0x00/cout 1/id 1.
- Fairness:
  - Stimulus: both req held high across 4 operations.
  - Required: grant order 0,1,0,1; each grant WIDTH+1 cycles after the previous one; never a double gnt.
- Reset mid-operation:
  - Stimulus: drop rst_n during bit 3 of a req0 add.
  - Required: all outputs 0 immediately, with no clock edge needed; no done pulse.
  - After release, with req1 held, gnt1 is issued; then with both held, req0 wins.
- Ignored request and result hold:
  - Stimulus: pulse req1 for 2 cycles while RUN is active, then drop it.
  - Required: no gnt1; sum/cout keep the previous result until the next done.

Source files
------------

// File: rtl/serial_add_arbiter.sv
// Two-port round-robin arbiter in front of one shared full-adder cell that is
// stepped LSB-first, one bit per clock, to produce a WIDTH-bit sum and carry.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last;
  logic             r_owner;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;

  logic             w_win;
  logic             w_win_id;
  logic             w_last_step;
  logic             w_fa_s;
  logic             w_fa_cout;
  logic [WIDTH:0]   w_res_shift;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_cin;

  full_adder u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_s    (w_fa_s),
    .o_cout (w_fa_cout)
  );

  // New sum bit enters at the MSB so the result ends up LSB-aligned after WIDTH steps.
  assign w_res_shift = {w_fa_s, r_res};
  assign w_res_next  = w_res_shift[WIDTH:1];
  assign w_last_step = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));

  // Round-robin arbitration; only open while idle or presenting a result.
  always_comb begin
    w_win    = 1'b0;
    w_win_id = 1'b0;
    if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
      if (req0 && req1) begin
        w_win    = 1'b1;
        w_win_id = ~r_last;
      end else if (req0) begin
        w_win    = 1'b1;
        w_win_id = 1'b0;
      end else if (req1) begin
        w_win    = 1'b1;
        w_win_id = 1'b1;
      end else begin
        w_win    = 1'b0;
        w_win_id = 1'b0;
      end
    end else begin
      w_win    = 1'b0;
      w_win_id = 1'b0;
    end
  end

  // Winner operand select
  always_comb begin
    w_sel_a   = a0;
    w_sel_b   = b0;
    w_sel_cin = cin0;
    if (w_win_id) begin
      w_sel_a   = a1;
      w_sel_b   = b1;
      w_sel_cin = cin1;
    end else begin
      w_sel_a   = a0;
      w_sel_b   = b0;
      w_sel_cin = cin0;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: w_next_state = w_win ? ST_RUN : ST_IDLE;
      ST_RUN:  w_next_state = w_last_step ? ST_DONE : ST_RUN;
      ST_DONE: w_next_state = w_win ? ST_RUN : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand capture on grant, then one bit step per cycle while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
    end else if (w_win) begin
      r_last  <= w_win_id;
      r_owner <= w_win_id;
      r_carry <= w_sel_cin;
      r_cnt   <= '0;
      r_a_sr  <= w_sel_a;
      r_b_sr  <= w_sel_b;
      r_res   <= '0;
    end else if (r_state == ST_RUN) begin
      r_carry <= w_fa_cout;
      r_cnt   <= r_cnt + CW'(1);
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_res   <= w_res_next;
    end
  end

  // Registered outputs; sum/cout/done_id only move on the final bit step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      gnt0 <= w_win & ~w_win_id;
      gnt1 <= w_win & w_win_id;
      busy <= (w_next_state == ST_RUN);
      done <= w_last_step;
      if (w_last_step) begin
        sum     <= w_res_next;
        cout    <= w_fa_cout;
        done_id <= r_owner;
      end
    end
  end

endmodule
